// File: rtl/io_port_ctrl.sv
// Memory-mapped IO port: debounced continue button gates switch reads into the core,
// and a bank of write-only output channels with a sticky bad-address flag.
module io_port_ctrl #(
  parameter int DATA_W     = 32,
  parameter int IN_W       = 18,
  parameter int N_OUT      = 3,
  parameter int ADDR_W     = 21,
  parameter int DEB_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    write_o,
  input  logic                    read_i,
  input  logic [IN_W-1:0]         sw_in,
  input  logic                    cont_n,
  output logic [DATA_W-1:0]       rdata,
  output logic                    stall,
  output logic [N_OUT*DATA_W-1:0] out_bus,
  output logic                    addr_err
);

  localparam int CNT_W      = $clog2(DEB_CYCLES);
  localparam int ARM_CYCLES = DEB_CYCLES + 2;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             armed_q, armed_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  state_t           state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic             addr_err_q, addr_err_d;
  logic             capture;

  // Synchronizer and debouncer. Presses are only reported once "armed": either the
  // line has been seen high long enough after reset, or the debounced level has risen.
  // This keeps a button held through reset from looking like a fresh press.
  always_comb begin
    s1_d      = cont_n;
    s2_d      = s1_q;
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
        press_d  = stable_q && armed_q;
        if (!stable_q) begin
          armed_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (!s2_q) begin
      arm_cnt_d = '0;
    end else if (arm_cnt_q != ARM_DONE) begin
      arm_cnt_d = arm_cnt_q + 1'b1;
    end
    if (arm_cnt_q == ARM_DONE) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      armed_q   <= armed_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // Read handshake FSM: state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; dropping read_i while waiting abandons the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (read_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!read_i) begin
          state_d = ST_IDLE;
        end else if (press_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: the core is released only in the DONE cycle.
  always_comb begin
    stall   = read_i && (state_q != ST_DONE) && !reset;
    capture = (state_q == ST_WAIT) && read_i && press_q;
  end

  always_comb begin
    rdata_d    = capture ? DATA_W'(sw_in) : rdata_q;
    addr_err_d = addr_err_q || (write_o && (addr >= ADDR_W'(N_OUT)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rdata    = rdata_q;
  assign addr_err = addr_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_chan
      logic [DATA_W-1:0] chan_q, chan_d;

      always_comb begin
        chan_d = chan_q;
        if (write_o && (addr == ADDR_W'(gi))) begin
          chan_d = wdata;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          chan_q <= '0;
        end else begin
          chan_q <= chan_d;
        end
      end

      assign out_bus[gi*DATA_W +: DATA_W] = chan_q;
    end
  endgenerate

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: scoreboard queues hold expected captures
// and expected output-bus images; each task checks its own scenario.
module tb_io_port_ctrl;
  localparam int DATA_W = 32;
  localparam int IN_W   = 18;
  localparam int N_OUT  = 3;
  localparam int ADDR_W = 21;
  localparam int DEB    = 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [ADDR_W-1:0]       addr = '0;
  logic [DATA_W-1:0]       wdata = '0;
  logic                    write_o = 1'b0;
  logic                    read_i = 1'b0;
  logic [IN_W-1:0]         sw_in = '0;
  logic                    cont_n = 1'b1;
  logic [DATA_W-1:0]       rdata;
  logic                    stall;
  logic [N_OUT*DATA_W-1:0] out_bus;
  logic                    addr_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0]       rd_q[$];
  logic [N_OUT*DATA_W-1:0] wr_q[$];
  logic [N_OUT*DATA_W-1:0] out_model = '0;
  logic                    err_model = 1'b0;
  logic [DATA_W-1:0]       last_rdata = '0;

  io_port_ctrl #(
    .DATA_W(DATA_W), .IN_W(IN_W), .N_OUT(N_OUT), .ADDR_W(ADDR_W), .DEB_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .write_o(write_o),
    .read_i(read_i), .sw_in(sw_in), .cont_n(cont_n), .rdata(rdata), .stall(stall),
    .out_bus(out_bus), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one write for the next edge and push the expected bus image.
  task automatic drive_write(input int a, input logic [DATA_W-1:0] d);
    addr    = ADDR_W'(a);
    wdata   = d;
    write_o = 1'b1;
    if (a < N_OUT) out_model[a*DATA_W +: DATA_W] = d;
    else err_model = 1'b1;
    wr_q.push_back(out_model);
    tick();
    write_o = 1'b0;
  endtask

  // Waits for the DONE cycle (stall low while read_i high); counts stall-high negedges.
  task automatic wait_done(output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (stall === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; read_i = 1'b1; write_o = 1'b1; addr = '0; wdata = '1; cont_n = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    write_o = 1'b0; read_i = 1'b0;
    tick();
    reset = 1'b0;
    out_model = '0; err_model = 1'b0; last_rdata = '0;
    rd_q.delete(); wr_q.delete();
    tick();
    @(negedge clock);
    n_cmp++;
    if (out_bus !== out_model) begin n_err++; $display("FAIL reset_out_bus: got %h want %h", out_bus, out_model); end
    n_cmp++;
    if (rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL reset_idle_stall: got %b want 0", stall); end
    n_cmp++;
    if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    repeat (10) tick();
  endtask

  task automatic test_write();
    logic [N_OUT*DATA_W-1:0] exp;
    drive_write(2, 32'hDEADBEEF);
    exp = wr_q.pop_front();
    @(negedge clock);
    n_cmp++;
    if (out_bus !== exp) begin n_err++; $display("FAIL write_ch2: got %h want %h", out_bus, exp); end
    n_cmp++;
    if (addr_err !== 1'b0) begin n_err++; $display("FAIL write_ch2_err: got %b want 0", addr_err); end
  endtask

  task automatic test_bad_addr();
    logic [N_OUT*DATA_W-1:0] exp;
    drive_write(3, 32'h12345678);
    exp = wr_q.pop_front();
    @(negedge clock);
    n_cmp++;
    if (out_bus !== exp) begin n_err++; $display("FAIL bad_addr3_bus: got %h want %h", out_bus, exp); end
    n_cmp++;
    if (addr_err !== err_model) begin n_err++; $display("FAIL bad_addr3_err: got %b want %b", addr_err, err_model); end
    drive_write(32'h100002, 32'hCAFEF00D);
    exp = wr_q.pop_front();
    @(negedge clock);
    n_cmp++;
    if (out_bus !== exp) begin n_err++; $display("FAIL bad_addr_high_bus: got %h want %h", out_bus, exp); end
    drive_write(1, 32'h0000_5A5A);
    exp = wr_q.pop_front();
    @(negedge clock);
    n_cmp++;
    if (out_bus !== exp || addr_err !== 1'b1) begin
      n_err++; $display("FAIL addr_err_sticky: got bus %h err %b want %h err 1", out_bus, addr_err, exp);
    end
  endtask

  // Consecutive-cycle writes while the core is stalled in WAIT.
  task automatic test_back_to_back();
    logic [N_OUT*DATA_W-1:0] exp;
    read_i = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_write(i % N_OUT, $urandom);
      exp = wr_q.pop_front();
      @(negedge clock);
      n_cmp++;
      if (out_bus !== exp) begin n_err++; $display("FAIL b2b_write%0d: got %h want %h", i, out_bus, exp); end
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall%0d: got %b want 1", i, stall); end
    end
    read_i = 1'b0;
    tick();
  endtask

  task automatic test_read_latency();
    int cyc; bit to;
    logic [DATA_W-1:0] exp;
    read_i = 1'b1; sw_in = 18'h2A5A5;
    repeat (2) tick();
    cont_n = 1'b0;
    rd_q.push_back(32'h0002A5A5);
    wait_done(cyc, to);
    n_cmp++;
    if (to || rd_q.size() == 0) begin
      n_err++; $display("FAIL latency_capture: got timeout want DONE");
    end else begin
      exp = rd_q.pop_front();
      if (rdata !== exp) begin n_err++; $display("FAIL latency_rdata: got %h want %h", rdata, exp); end
      last_rdata = exp;
    end
    n_cmp++;
    if (cyc != DEB + 3) begin n_err++; $display("FAIL latency_cycles: got %0d want %0d", cyc, DEB + 3); end
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b1) begin n_err++; $display("FAIL latency_restall: got %b want 1", stall); end
    read_i = 1'b0; cont_n = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_glitch();
    read_i = 1'b1; sw_in = 18'h00FFF;
    tick();
    cont_n = 1'b0;
    repeat (DEB - 1) tick();
    cont_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL glitch_stall%0d: got %b want 1", i, stall); end
    end
    n_cmp++;
    if (rdata !== last_rdata) begin n_err++; $display("FAIL glitch_rdata: got %h want %h", rdata, last_rdata); end
    read_i = 1'b0;
    tick();
  endtask

  task automatic test_press_in_idle();
    read_i = 1'b0; cont_n = 1'b0;
    repeat (10) tick();
    read_i = 1'b1; sw_in = 18'h11111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL idle_press_stall%0d: got %b want 1", i, stall); end
    end
    cont_n = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if (rdata !== last_rdata) begin n_err++; $display("FAIL idle_press_rdata: got %h want %h", rdata, last_rdata); end
    read_i = 1'b0;
    tick();
  endtask

  task automatic test_held_button();
    int cyc; bit to;
    logic [DATA_W-1:0] exp;
    read_i = 1'b1; sw_in = 18'h15555;
    tick();
    cont_n = 1'b0;
    rd_q.push_back(32'h00015555);
    wait_done(cyc, to);
    n_cmp++;
    if (to || rd_q.size() == 0) begin
      n_err++; $display("FAIL held_first: got timeout want DONE");
    end else begin
      exp = rd_q.pop_front();
      if (rdata !== exp) begin n_err++; $display("FAIL held_first_rdata: got %h want %h", rdata, exp); end
    end
    sw_in = 18'h3C3C3;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL held_no_retrigger%0d: got %b want 1", i, stall); end
    end
    n_cmp++;
    if (rdata !== 32'h00015555) begin n_err++; $display("FAIL held_rdata_hold: got %h want 00015555", rdata); end
    cont_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clock);
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL held_release%0d: got %b want 1", i, stall); end
    end
    cont_n = 1'b0;
    rd_q.push_back(32'h0003C3C3);
    wait_done(cyc, to);
    n_cmp++;
    if (to || rd_q.size() == 0) begin
      n_err++; $display("FAIL held_second: got timeout want DONE");
    end else begin
      exp = rd_q.pop_front();
      if (rdata !== exp) begin n_err++; $display("FAIL held_second_rdata: got %h want %h", rdata, exp); end
      last_rdata = exp;
    end
    cont_n = 1'b1; read_i = 1'b0;
    repeat (10) tick();
  endtask

  // Reset lands on the same edge as the capture and a channel-0 write.
  task automatic test_reset_in_wait();
    int cyc; bit to;
    logic [DATA_W-1:0] exp;
    read_i = 1'b1; sw_in = 18'h2BEEF;
    repeat (2) tick();
    cont_n = 1'b0;
    repeat (DEB + 2) tick();
    reset = 1'b1; write_o = 1'b1; addr = '0; wdata = 32'hA5A5A5A5;
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL rst_wait_stall: got %b want 0", stall); end
    tick();
    reset = 1'b0; write_o = 1'b0;
    out_model = '0; err_model = 1'b0; last_rdata = '0;
    @(negedge clock);
    n_cmp++;
    if (rdata !== '0) begin n_err++; $display("FAIL rst_wait_rdata: got %h want 0", rdata); end
    n_cmp++;
    if (out_bus !== out_model) begin n_err++; $display("FAIL rst_wait_out_bus: got %h want %h", out_bus, out_model); end
    n_cmp++;
    if (addr_err !== 1'b0) begin n_err++; $display("FAIL rst_wait_addr_err: got %b want 0", addr_err); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      n_cmp++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL rst_held_stall%0d: got %b want 1", i, stall); end
    end
    cont_n = 1'b1;
    repeat (8) tick();
    cont_n = 1'b0;
    rd_q.push_back(32'h0002BEEF);
    wait_done(cyc, to);
    n_cmp++;
    if (to || rd_q.size() == 0) begin
      n_err++; $display("FAIL rst_repress: got timeout want DONE");
    end else begin
      exp = rd_q.pop_front();
      if (rdata !== exp) begin n_err++; $display("FAIL rst_repress_rdata: got %h want %h", rdata, exp); end
    end
    cont_n = 1'b1; read_i = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_addr();
    test_back_to_back();
    test_read_latency();
    test_glitch();
    test_press_in_idle();
    test_held_button();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
